// File: rtl/home_sequencer.sv
// Homing sequencer: homes each enabled motor in turn through a step_req/step_ack handshake.
// Optional seek timeout fault is enabled by defining HOME_SEQ_TIMEOUT_EN.
module home_sequencer #(
  parameter int MAX_STEPS     = 1000,
  parameter int BACKOFF_STEPS = 16,
  parameter int SETTLE_CYC    = 1000
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] mask,
  input  logic [5:0] Stop,
  input  logic       step_ack,
  output logic       step_req,
  output logic [5:0] motor_sel,
  output logic       dir,
  output logic [5:0] MF,
  output logic [5:0] initFlag,
  output logic [5:0] err,
  output logic       busy,
  output logic       INIT
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SELECT  = 3'd1;
  localparam logic [2:0] S_SEEK    = 3'd2;
  localparam logic [2:0] S_BACKOFF = 3'd3;
  localparam logic [2:0] S_SETTLE  = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam int BW = $clog2(BACKOFF_STEPS + 1);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam logic [9:0]    SEEK_LIMIT   = (MAX_STEPS > 1023) ? 10'd1023 : 10'(MAX_STEPS);
  localparam logic [BW-1:0] BACKOFF_LAST = BW'(BACKOFF_STEPS);
  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYC - 1);

  function automatic logic [5:0] onehot6(input logic [2:0] idx);
    onehot6 = 6'b000001 << idx;
  endfunction

  function automatic logic [2:0] lowest_idx(input logic [5:0] vec);
    logic [2:0] r;
    r = 3'd0;
    for (int k = 5; k >= 0; k--) begin
      if (vec[k]) begin
        r = 3'(k);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  logic [5:0]    stop_m_q, stop_s_q;
  logic [2:0]    state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [5:0]    pend_q, pend_d;
  logic [9:0]    seek_cnt_q, seek_cnt_d;
  logic [BW-1:0] bo_cnt_q, bo_cnt_d;
  logic [SW-1:0] settle_cnt_q, settle_cnt_d;
  logic          req_q, req_d;
  logic [5:0]    sel_q, sel_d;
  logic          dir_q, dir_d;
  logic [5:0]    init_flag_q, init_flag_d;
  logic [5:0]    err_q, err_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [5:0]    cur_bit_s;
  logic          stop_cur_s;
  logic          axis_active_s;

  // Limit switches are asynchronous; two-flop synchronizer per bit.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      stop_m_q <= 6'b000000;
      stop_s_q <= 6'b000000;
    end else begin
      stop_m_q <= Stop;
      stop_s_q <= stop_m_q;
    end
  end

  assign cur_bit_s  = onehot6(idx_q);
  assign stop_cur_s = |(stop_s_q & cur_bit_s);

  // Sequencer next-state, counters and handshake.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pend_d       = pend_q;
    seek_cnt_d   = seek_cnt_q;
    bo_cnt_d     = bo_cnt_q;
    settle_cnt_d = settle_cnt_q;
    req_d        = req_q;
    init_flag_d  = init_flag_q;
    err_d        = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          pend_d      = mask;
          init_flag_d = 6'b000000;
          err_d       = 6'b000000;
          state_d     = S_SELECT;
        end else begin
          state_d = state_q;
        end
      end
      S_SELECT: begin
        if (pend_q == 6'b000000) begin
          state_d = S_DONE;
        end else begin
          idx_d      = lowest_idx(pend_q);
          seek_cnt_d = 10'd0;
          req_d      = 1'b0;
          state_d    = S_SEEK;
        end
      end
      S_SEEK: begin
        // An outstanding request is always completed before Stop is looked at.
        if (req_q) begin
          if (step_ack) begin
            req_d      = 1'b0;
            seek_cnt_d = (seek_cnt_q == SEEK_LIMIT) ? seek_cnt_q : seek_cnt_q + 10'd1;
          end else begin
            req_d = 1'b1;
          end
        end else if (stop_cur_s) begin
          bo_cnt_d = '0;
          state_d  = S_BACKOFF;
`ifdef HOME_SEQ_TIMEOUT_EN
        end else if (seek_cnt_q == SEEK_LIMIT) begin
          err_d   = err_q | cur_bit_s;
          pend_d  = pend_q & ~cur_bit_s;
          state_d = S_SELECT;
`endif
        end else begin
          req_d = 1'b1;
        end
      end
      S_BACKOFF: begin
        if (req_q) begin
          if (step_ack) begin
            req_d    = 1'b0;
            bo_cnt_d = bo_cnt_q + BW'(1);
          end else begin
            req_d = 1'b1;
          end
        end else if (bo_cnt_q == BACKOFF_LAST) begin
          if (stop_cur_s) begin
            err_d   = err_q | cur_bit_s;
            pend_d  = pend_q & ~cur_bit_s;
            state_d = S_SELECT;
          end else begin
            settle_cnt_d = '0;
            state_d      = S_SETTLE;
          end
        end else begin
          req_d = 1'b1;
        end
      end
      S_SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          init_flag_d = init_flag_q | cur_bit_s;
          pend_d      = pend_q & ~cur_bit_s;
          state_d     = S_SELECT;
        end else begin
          settle_cnt_d = settle_cnt_q + SW'(1);
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Output registers are derived from the upcoming state so they align with it.
  always_comb begin
    axis_active_s = (state_d == S_SEEK) || (state_d == S_BACKOFF) || (state_d == S_SETTLE);
    sel_d  = axis_active_s ? onehot6(idx_d) : 6'b000000;
    dir_d  = (state_d == S_BACKOFF);
    busy_d = !((state_d == S_IDLE) || (state_d == S_DONE));
    done_d = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= 3'd0;
      pend_q       <= 6'b000000;
      seek_cnt_q   <= 10'd0;
      bo_cnt_q     <= '0;
      settle_cnt_q <= '0;
      req_q        <= 1'b0;
      sel_q        <= 6'b000000;
      dir_q        <= 1'b0;
      init_flag_q  <= 6'b000000;
      err_q        <= 6'b000000;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      seek_cnt_q   <= seek_cnt_d;
      bo_cnt_q     <= bo_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      req_q        <= req_d;
      sel_q        <= sel_d;
      dir_q        <= dir_d;
      init_flag_q  <= init_flag_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign step_req  = req_q;
  assign motor_sel = sel_q;
  assign MF        = sel_q;
  assign dir       = dir_q;
  assign initFlag  = init_flag_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign INIT      = done_q;

endmodule

// File: tb/tb_home_sequencer.sv
// Scoreboard bench for home_sequencer: a randomly-delayed step responder, an expected-event
// queue filled by the stimulus, and a negedge monitor that pops and compares.
module tb_home_sequencer;
  localparam int BO = 16;
  localparam int SC = 20;
  localparam int MS = 8;

  logic       sysclk = 1'b0;
  logic       rst, start, step_ack;
  logic [5:0] mask, Stop;
  logic       step_req, dir, busy, INIT;
  logic [5:0] motor_sel, MF, initFlag, err;

  typedef struct {
    bit         is_done;
    logic [5:0] a;
    logic [5:0] b;
    logic       d;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // stimulus-owned controls for the limit switches
  int         stop_after_n;
  logic [5:0] stop_bits, stop_preset;
  bit         release_en;
  int         gen = 0;
  // responder-owned state
  int         ack_cnt;
  int         seen_gen;
  logic [5:0] trig_bits, rel_bits;

  assign Stop = (stop_preset | trig_bits) & ~rel_bits;

  always #5 sysclk = ~sysclk;

  home_sequencer #(.MAX_STEPS(MS), .BACKOFF_STEPS(BO), .SETTLE_CYC(SC)) dut (
    .sysclk(sysclk), .rst(rst), .start(start), .mask(mask), .Stop(Stop),
    .step_ack(step_ack), .step_req(step_req), .motor_sel(motor_sel), .dir(dir),
    .MF(MF), .initFlag(initFlag), .err(err), .busy(busy), .INIT(INIT)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push_steps(input logic [5:0] m, input logic dv, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back('{is_done: 1'b0, a: m, b: 6'd0, d: dv});
  endtask

  task automatic push_done(input logic [5:0] fl, input logic [5:0] er);
    exp_q.push_back('{is_done: 1'b1, a: fl, b: er, d: 1'b0});
  endtask

  // Pulse-generator model: acks each request after 0..20 cycles, occasionally sends stray acks.
  initial begin
    step_ack = 1'b0; ack_cnt = 0; seen_gen = 0; trig_bits = 6'd0; rel_bits = 6'd0;
    forever begin
      @(posedge sysclk); #1;
      if (seen_gen != gen) begin
        seen_gen = gen; ack_cnt = 0; trig_bits = 6'd0; rel_bits = 6'd0;
      end
      if (step_req === 1'b1 && rst === 1'b0) begin
        repeat ($urandom_range(0, 20)) begin @(posedge sysclk); #1; end
        if (step_req === 1'b1 && rst === 1'b0) begin
          step_ack = 1'b1;
          ack_cnt++;
          if (ack_cnt == stop_after_n) trig_bits = stop_bits;
          if (release_en && dir === 1'b1) rel_bits = rel_bits | motor_sel;
          @(posedge sysclk); #1;
          step_ack = 1'b0;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        step_ack = 1'b1;
        @(posedge sysclk); #1;
        step_ack = 1'b0;
      end
    end
  end

  // Monitor: pops one expected event per accepted step and per INIT rising edge.
  initial begin
    bit   prev_req, prev_init, acked;
    exp_t e;
    prev_req = 1'b0; prev_init = 1'b0; acked = 1'b0;
    forever begin
      @(negedge sysclk);
      if (rst !== 1'b0) begin
        prev_req = 1'b0; prev_init = 1'b0; acked = 1'b0;
      end else begin
        if (prev_req && !step_req) begin
          chk("req_dropped_only_after_ack", {31'd0, acked}, 32'd1);
          acked = 1'b0;
        end
        if (step_req && step_ack) begin
          acked = 1'b1;
          if (exp_q.size() == 0) begin
            chk("unexpected_step", {26'd0, motor_sel}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("step_kind", {31'd0, e.is_done}, 32'd0);
            chk("step_motor_sel", {26'd0, motor_sel}, {26'd0, e.a});
            chk("step_MF", {26'd0, MF}, {26'd0, e.a});
            chk("step_dir", {31'd0, dir}, {31'd0, e.d});
          end
        end
        if (INIT && !prev_init) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", {26'd0, initFlag}, 32'hFFFF);
          end else begin
            e = exp_q.pop_front();
            chk("done_kind", {31'd0, e.is_done}, 32'd1);
            chk("done_initFlag", {26'd0, initFlag}, {26'd0, e.a});
            chk("done_err", {26'd0, err}, {26'd0, e.b});
            chk("done_busy", {31'd0, busy}, 32'd0);
          end
        end
        prev_req  = step_req;
        prev_init = INIT;
      end
    end
  end

  task automatic setup(input logic [5:0] preset, input logic [5:0] bits, input int after_n, input bit rel);
    stop_preset = preset; stop_bits = bits; stop_after_n = after_n; release_en = rel;
    gen++;
    repeat (3) @(posedge sysclk);
  endtask

  task automatic pulse_start(input logic [5:0] m);
    @(posedge sysclk); #1;
    mask = m; start = 1'b1;
    @(posedge sysclk); #1;
    start = 1'b0;
  endtask

  task automatic do_start(input logic [5:0] m);
    pulse_start(m);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("INIT_cleared_on_start", {31'd0, INIT}, 32'd0);
    chk("initFlag_cleared_on_start", {26'd0, initFlag}, 32'd0);
    chk("err_cleared_on_start", {26'd0, err}, 32'd0);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 30000) begin
      @(negedge sysclk);
      n++;
    end
    chk(name, exp_q.size(), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge sysclk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_step_req"}, {31'd0, step_req}, 32'd0);
    chk({tag, "_motor_sel"}, {26'd0, motor_sel}, 32'd0);
    chk({tag, "_dir"}, {31'd0, dir}, 32'd0);
    chk({tag, "_MF"}, {26'd0, MF}, 32'd0);
    chk({tag, "_initFlag"}, {26'd0, initFlag}, 32'd0);
    chk({tag, "_err"}, {26'd0, err}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_INIT"}, {31'd0, INIT}, 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; mask = 6'd0;
    stop_preset = 6'd0; stop_bits = 6'd0; stop_after_n = -1; release_en = 1'b0;
    repeat (3) @(posedge sysclk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // motor 0; Stop rises with the 5th ack, one overshoot step through the synchronizer
    setup(6'd0, 6'b000001, 5, 1'b1);
    push_steps(6'b000001, 1'b0, 6);
    push_steps(6'b000001, 1'b1, BO);
    push_done(6'b000001, 6'b000000);
    do_start(6'b000001);
    chk("select_cycle_motor_sel", {26'd0, motor_sel}, 32'd0);
    @(posedge sysclk); #1;
    chk("seek_entry_motor_sel", {26'd0, motor_sel}, 32'd1);
    chk("seek_entry_no_req", {31'd0, step_req}, 32'd0);
    @(posedge sysclk); #1;
    chk("seek_first_req", {31'd0, step_req}, 32'd1);
    n = 0;
    while (ack_cnt < 2 && n < 2000) begin @(posedge sysclk); n++; end
    chk("t1_reach_two_acks", {31'd0, (ack_cnt >= 2)}, 32'd1);
    pulse_start(6'b111111);
    wait_drain("t1_drain");

    // Stop already high on motors 0, 2, 5: backoff only, released during backoff
    setup(6'b100101, 6'd0, -1, 1'b1);
    push_steps(6'b000001, 1'b1, BO);
    push_steps(6'b000100, 1'b1, BO);
    push_steps(6'b100000, 1'b1, BO);
    push_done(6'b100101, 6'b000000);
    do_start(6'b100101);
    wait_drain("t2_drain");

    // Stop held through backoff: fault
    setup(6'b000010, 6'd0, -1, 1'b0);
    push_steps(6'b000010, 1'b1, BO);
    push_done(6'b000000, 6'b000010);
    do_start(6'b000010);
    wait_drain("t3_drain");

    // empty mask completes immediately
    setup(6'd0, 6'd0, -1, 1'b0);
    push_done(6'b000000, 6'b000000);
    do_start(6'b000000);
    wait_drain("t4_drain");

`ifdef HOME_SEQ_TIMEOUT_EN
    // Stop never asserts: each axis times out after MS steps
    setup(6'd0, 6'd0, -1, 1'b0);
    push_steps(6'b000001, 1'b0, MS);
    push_steps(6'b000010, 1'b0, MS);
    push_done(6'b000000, 6'b000011);
    do_start(6'b000011);
    wait_drain("t5_drain");
`endif

    // asynchronous reset while a request is outstanding
    setup(6'd0, 6'd0, -1, 1'b0);
    do_start(6'b000011);
    n = 0;
    while (step_req !== 1'b1 && n < 200) begin @(posedge sysclk); #2; n++; end
    chk("t6_req_seen", {31'd0, step_req}, 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midstep_reset");
    exp_q.delete();
    repeat (2) @(posedge sysclk);
    #1 rst = 1'b0;
    setup(6'b000001, 6'd0, -1, 1'b1);
    push_steps(6'b000001, 1'b1, BO);
    push_done(6'b000001, 6'b000000);
    do_start(6'b000001);
    wait_drain("t6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/home_sequencer.md
# home_sequencer

Homing sequencer for the six-axis stepper subsystem. On a start pulse it homes each enabled motor in turn: drives it toward its limit switch one step at a time through a request/acknowledge handshake with the pulse generator, then backs off a fixed number of steps, waits for the axis to settle, and sets that motor's init flag. It sits between the keypad/control logic and the pulse generator. It owns the pulse generator until every enabled axis is homed or has faulted.

## Interface
Parameters:
- MAX_STEPS, 1000: seek-step limit per motor (10-bit counter).
- BACKOFF_STEPS, 16: steps driven away from the switch after it trips.
- SETTLE_CYC, 1000: sysclk cycles waited after backoff.

Ports:
- sysclk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin or restart homing.
- mask  in  6  per-motor enable; 1 = home this motor. Sampled on an accepted start.
- Stop  in  6  limit switches, active-high, asynchronous to sysclk.
- step_ack  in  1  one-cycle pulse from the pulse generator when the requested step has been issued.
- step_req  out  1  step request to the pulse generator.
- motor_sel  out  6  one-hot selection of the motor being stepped; all zeros when no motor is selected.
- dir  out  1  step direction; 0 = toward home, 1 = away.
- MF  out  6  motor power enable; the selected motor only.
- initFlag  out  6  per-motor homed flag.
- err  out  6  per-motor fault flag.
- busy  out  1  high while the sequence is running.
- INIT  out  1  high when the sequence has completed.

## Operation
- Stop is passed through a 2-flop synchronizer. Decisions use stop_s, the synchronized value.
- States:
  - IDLE: waiting for start.
  - SELECT: choose the lowest unprocessed index i with mask_r[i] set; if there is none, go to DONE.
  - SEEK: dir=0.
    - If stop_s[i]=1, go to BACKOFF with no step issued.
    - Otherwise assert step_req, wait for step_ack, increment seek_cnt, then re-evaluate.
  - BACKOFF: dir=1. Issue exactly BACKOFF_STEPS steps.
    - After the last ack: if stop_s[i] is still 1, set err[i] and go to SELECT.
    - Otherwise go to SETTLE.
  - SETTLE: count SETTLE_CYC cycles, then set initFlag[i] and go to SELECT.
  - DONE: INIT=1, busy=0. A new start is accepted here.
- Accepting start (in IDLE or DONE):
  - latch mask into mask_r;
  - clear initFlag, err and INIT;
  - set busy.
- start while busy is ignored.
- If mask=0 at start: SELECT goes straight to DONE.
- motor_sel and MF are one-hot on i during SEEK, BACKOFF and SETTLE, and zero otherwise.
- seek_cnt and backoff_cnt clear on every entry to SEEK and BACKOFF respectively.

## Timing
- Reset values: step_req=0, motor_sel=0, dir=0, MF=0, initFlag=0, err=0, busy=0, INIT=0; state=IDLE.
- start is sampled on cycle N; busy=1 from cycle N+1. SELECT occupies exactly one cycle.
- step_req rises the cycle after SEEK is entered or re-evaluated.
  - It is held until step_ack is sampled high, then drops the following cycle.
  - It is low for at least one cycle between requests.
  - dir and motor_sel are stable while step_req=1.
- A Stop rising edge is visible in stop_s 2 cycles later.
  - An outstanding request is never abandoned: its ack is awaited first, and the Stop is acted on at the next re-evaluation.
  - Worst-case overshoot is one step.
- step_ack arriving while step_req=0 is ignored.
- Asynchronous rst mid-step drops step_req immediately and returns to IDLE.

## Configuration
- HOME_SEQ_TIMEOUT_EN defined:
  - In SEEK, when seek_cnt reaches MAX_STEPS with stop_s[i]=0, set err[i], leave initFlag[i]=0, and go to SELECT.
  - No backoff is performed in this case.
- Undefined: SEEK continues until Stop, with no step limit.

## Test plan
- Reset, then start with mask=6'b000001; Stop[0] asserts after the 5th ack → exactly 5 seek steps (6 if overshoot), then 16 backoff steps with dir=1, SETTLE_CYC cycles, then initFlag=6'b000001, INIT=1, busy=0.
- mask=6'b100101 with Stop[i] already high at start → no seek steps, 16 backoff steps per motor in order 0, 2, 5; initFlag=6'b100101.
- With HOME_SEQ_TIMEOUT_EN and MAX_STEPS=8, Stop never asserts → 8 steps, err[0]=1, initFlag[0]=0, sequence proceeds to the next motor.
- Stop held high through backoff → err[i]=1, initFlag[i]=0.
- start pulsed during SEEK → ignored. rst asserted with step_req=1 → step_req=0 and all outputs at reset values the same cycle; a new start homes from motor 0.
- Handshake check: step_ack delayed 0–20 cycles at random → no step counted twice, and step_req never deasserts before its ack.
